// File: rtl/pipe_hazard_apply.sv
// pipe_hazard_apply: turns hazard-unit stall/flush decisions into pipeline
// register enables and squash controls, drives the EX operand forwarding muxes,
// and keeps the stalled feedback, held write-back value and perf counters.
module pipe_hazard_apply #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       forward_a,
  input  logic [1:0]       forward_b,
  input  logic [XLEN-1:0]  rs1_data_e,
  input  logic [XLEN-1:0]  rs2_data_e,
  input  logic [XLEN-1:0]  ex_mem_result,
  input  logic [XLEN-1:0]  mem_wb_result,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             stalled,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_HELD = 2'b11
  } fwd_sel_e;

  logic             stalled_q, stalled_d;
  logic [XLEN-1:0]  held_q, held_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // A flush squashes the stalled consumer, so the stall only counts without one.
  logic stall_eff;
  assign stall_eff = stall & ~flush;

  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] wb,
    input logic [XLEN-1:0] mem,
    input logic [XLEN-1:0] held
  );
    logic [XLEN-1:0] r;
    case (fwd_sel_e'(sel))
      FWD_RF:   r = rf;
      FWD_WB:   r = wb;
      FWD_MEM:  r = mem;
      default:  r = held;
    endcase
    return r;
  endfunction

  // Stage controls: flush > stall > normal.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (flush) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // EX operand forwarding, same encoding for both operands.
  always_comb begin
    alu_a = fwd_mux(forward_a, rs1_data_e, mem_wb_result, ex_mem_result, held_q);
    alu_b = fwd_mux(forward_b, rs2_data_e, mem_wb_result, ex_mem_result, held_q);
  end

  // Next state: stalled flag, held WB value, saturating counters (clear wins).
  always_comb begin
    stalled_d   = stall_eff;
    held_d      = stall_eff ? mem_wb_result : held_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_eff && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalled_q   <= 1'b0;
      held_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stalled_q   <= stalled_d;
      held_q      <= held_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stalled   = stalled_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_apply.sv
// Randomized self-checking bench for pipe_hazard_apply with a behavioural model.
module tb_pipe_hazard_apply;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall, flush, cnt_clear;
  logic [1:0]       forward_a, forward_b;
  logic [XLEN-1:0]  rs1_data_e, rs2_data_e, ex_mem_result, mem_wb_result;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush, stalled;
  logic [XLEN-1:0]  alu_a, alu_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  bit              m_stalled;
  logic [XLEN-1:0] m_held;
  int              m_sc, m_fc;

  pipe_hazard_apply #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e),
    .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
    .cnt_clear(cnt_clear), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .stalled(stalled),
    .alu_a(alu_a), .alu_b(alu_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] pick(input logic [1:0] s, input logic [XLEN-1:0] rf);
    logic [XLEN-1:0] srcs [4];
    srcs[0] = rf; srcs[1] = mem_wb_result; srcs[2] = ex_mem_result; srcs[3] = m_held;
    return srcs[s];
  endfunction

  // expected {pc_write, if_id_write, if_id_flush, id_ex_flush}
  function automatic logic [3:0] ctl_exp();
    if (flush)      return 4'b1111;
    else if (stall) return 4'b0001;
    else            return 4'b1100;
  endfunction

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic tick();
    bit s_app;
    s_app = stall && !flush;
    @(posedge clk);
    if (!rst_n) begin
      m_stalled = 0; m_held = '0; m_sc = 0; m_fc = 0;
    end else begin
      m_stalled = s_app;
      if (s_app) m_held = mem_wb_result;
      if (cnt_clear) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (s_app && m_sc < CMAX) m_sc++;
        if (flush && m_fc < CMAX) m_fc++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; flush = 0; cnt_clear = 0;
    forward_a = 2'b11; forward_b = 2'b00;
    rs1_data_e = 32'h5; rs2_data_e = 32'h6; ex_mem_result = 32'h7; mem_wb_result = 32'h8;
    m_stalled = 0; m_held = '0; m_sc = 0; m_fc = 0;
    #3;
    checks++;
    if (stalled !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      failures++; $display("FAIL reset_state: stalled=%b sc=%0d fc=%0d want 0/0/0", stalled, stall_cnt, flush_cnt);
    end
    checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1100) begin
      failures++; $display("FAIL reset_ctl: got %b want 1100", {pc_write, if_id_write, if_id_flush, id_ex_flush});
    end
    checks++;
    if (alu_a !== 32'h0) begin
      failures++; $display("FAIL reset_held: alu_a=%h want 0", alu_a);
    end
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_stall();
    stall = 1; flush = 0; mem_wb_result = 32'hDEADBEEF; forward_b = 2'b11;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_flush, if_id_flush} !== 4'b0010) begin
      failures++; $display("FAIL stall_ctl: got %b want 0010", {pc_write, if_id_write, id_ex_flush, if_id_flush});
    end
    tick();
    stall = 0; mem_wb_result = 32'h1;
    #1;
    checks++;
    if (stalled !== 1'b1 || int'(stall_cnt) !== m_sc || m_sc != 1) begin
      failures++; $display("FAIL stall_reg: stalled=%b sc=%0d want 1/1", stalled, stall_cnt);
    end
    checks++;
    if (alu_b !== 32'hDEADBEEF) begin
      failures++; $display("FAIL stall_held: alu_b=%h want deadbeef", alu_b);
    end
    tick();
    checks++;
    if (stalled !== 1'b0 || alu_b !== 32'hDEADBEEF) begin
      failures++; $display("FAIL stall_release: stalled=%b alu_b=%h want 0/deadbeef", stalled, alu_b);
    end
  endtask

  task automatic test_flush_with_stall();
    int sc0;
    sc0 = m_sc;
    stall = 1; flush = 1; mem_wb_result = 32'hCAFE0000; forward_a = 2'b11;
    #1;
    checks++;
    if ({pc_write, if_id_flush, id_ex_flush, if_id_write} !== 4'b1111) begin
      failures++; $display("FAIL flush_ctl: got %b want 1111", {pc_write, if_id_flush, id_ex_flush, if_id_write});
    end
    tick();
    stall = 0; flush = 0;
    #1;
    checks++;
    if (stalled !== 1'b0 || int'(flush_cnt) !== m_fc || int'(stall_cnt) !== sc0) begin
      failures++; $display("FAIL flush_reg: stalled=%b fc=%0d sc=%0d want 0/%0d/%0d", stalled, flush_cnt, stall_cnt, m_fc, sc0);
    end
    checks++;
    if (alu_a !== 32'hDEADBEEF) begin
      failures++; $display("FAIL flush_held: alu_a=%h want deadbeef", alu_a);
    end
  endtask

  task automatic test_forward_mux();
    logic [XLEN-1:0] want [4];
    stall = 1; flush = 0; mem_wb_result = 32'h44;
    tick();
    stall = 0;
    rs1_data_e = 32'h11; rs2_data_e = 32'h11; mem_wb_result = 32'h22; ex_mem_result = 32'h33;
    want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33; want[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      forward_a = 2'(i); forward_b = 2'(3 - i);
      #1;
      checks++;
      if (alu_a !== want[i] || alu_b !== want[3 - i]) begin
        failures++; $display("FAIL fwd_sweep%0d: alu_a=%h alu_b=%h want %h/%h", i, alu_a, alu_b, want[i], want[3 - i]);
      end
    end
    tick();
  endtask

  task automatic test_saturation();
    flush = 1; stall = 0; cnt_clear = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 14) begin
        checks++;
        if (flush_cnt !== 4'hF) begin
          failures++; $display("FAIL sat_flush%0d: fc=%h want f", i, flush_cnt);
        end
      end
    end
    cnt_clear = 1;
    tick();
    cnt_clear = 0; flush = 0;
    #1;
    checks++;
    if (flush_cnt !== '0 || stall_cnt !== '0) begin
      failures++; $display("FAIL sat_clear: fc=%0d sc=%0d want 0/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      stall = 1'($urandom_range(0, 2) == 0 ? 1 : 0) | 1'(n % 23 < 3);
      flush = 1'($urandom_range(0, 4) == 0);
      cnt_clear = 1'($urandom_range(0, 40) == 0);
      forward_a = 2'($urandom); forward_b = 2'($urandom);
      rs1_data_e = $urandom; rs2_data_e = $urandom;
      ex_mem_result = $urandom; mem_wb_result = $urandom;
      #1;
      checks++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== ctl_exp() ||
          alu_a !== pick(forward_a, rs1_data_e) || alu_b !== pick(forward_b, rs2_data_e)) begin
        failures++; $display("FAIL rand_comb%0d: ctl=%b a=%h b=%h want %b/%h/%h", n,
          {pc_write, if_id_write, if_id_flush, id_ex_flush}, alu_a, alu_b,
          ctl_exp(), pick(forward_a, rs1_data_e), pick(forward_b, rs2_data_e));
      end
      tick();
      checks++;
      if (stalled !== m_stalled || int'(stall_cnt) !== m_sc || int'(flush_cnt) !== m_fc) begin
        failures++; $display("FAIL rand_reg%0d: stalled=%b sc=%0d fc=%0d want %b/%0d/%0d", n,
          stalled, stall_cnt, flush_cnt, m_stalled, m_sc, m_fc);
      end
    end
    stall = 0; flush = 0; cnt_clear = 0;
  endtask

  task automatic test_reset_mid_stall();
    stall = 1; flush = 0; mem_wb_result = 32'hABCD1234; forward_a = 2'b11;
    tick();
    checks++;
    if (stalled !== 1'b1 || alu_a !== 32'hABCD1234) begin
      failures++; $display("FAIL mid_pre: stalled=%b alu_a=%h want 1/abcd1234", stalled, alu_a);
    end
    #1 rst_n = 0;
    #1;
    m_stalled = 0; m_held = '0; m_sc = 0; m_fc = 0;
    checks++;
    if (stalled !== 1'b0 || alu_a !== 32'h0 || stall_cnt !== '0) begin
      failures++; $display("FAIL mid_reset: stalled=%b alu_a=%h sc=%0d want 0/0/0", stalled, alu_a, stall_cnt);
    end
    stall = 0;
    tick();
    rst_n = 1;
    tick();
    checks++;
    if (stalled !== 1'b0 || pc_write !== 1'b1) begin
      failures++; $display("FAIL mid_after: stalled=%b pc_write=%b want 0/1", stalled, pc_write);
    end
  endtask

  initial begin
    test_reset();
    test_single_stall();
    test_flush_with_stall();
    test_forward_mux();
    test_saturation();
    test_random();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_apply.md
# pipe_hazard_apply

Applies the hazard unit's decisions to the pipelined OTTER datapath. It sits between the hazard unit and the IF/ID, ID/EX and PC registers, and converts `stall`/`flush` into register write-enables and bubble/squash controls. It drives the EX-stage ALU operand muxes from the `forward_a`/`forward_b` selects, and generates the registered `stalled` feedback the hazard unit consumes. It also keeps a held write-back value for post-stall forwarding and saturating stall/flush performance counters.

## Interface
- `XLEN`, 32, datapath width
- `CNT_W`, 16, width of each performance counter

- `clk`  in  1  pipeline clock
- `rst_n`  in  1  asynchronous reset, active low
- `stall`  in  1  load-use stall request from the hazard unit
- `flush`  in  1  taken branch/jump in EX, from the hazard unit
- `forward_a`  in  2  ALU A select: 00 register file, 01 MEM/WB, 10 EX/MEM, 11 held value
- `forward_b`  in  2  ALU B select, same encoding as `forward_a`
- `rs1_data_e`, `rs2_data_e`  in  XLEN  ID/EX register-file operands
- `ex_mem_result`  in  XLEN  EX/MEM ALU result
- `mem_wb_result`  in  XLEN  final MEM/WB write-back data
- `cnt_clear`  in  1  synchronous clear of both counters
- `pc_write`  out  1  PC register enable
- `if_id_write`  out  1  IF/ID register enable
- `if_id_flush`  out  1  IF/ID load NOP (0x00000013)
- `id_ex_flush`  out  1  ID/EX load bubble (all control zero)
- `stalled`  out  1  registered: a stall was applied last cycle
- `alu_a`, `alu_b`  out  XLEN  forwarded EX operands
- `stall_cnt`, `flush_cnt`  out  CNT_W  cycles in which a stall or a flush was applied

## Operation
- Stage controls are combinational from the current `stall` and `flush`. Priority is flush > stall > normal.
  - Normal: `pc_write`=1, `if_id_write`=1, `if_id_flush`=0, `id_ex_flush`=0.
  - Stall only: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `if_id_flush`=0.
  - Flush, with or without stall: `pc_write`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_flush`=1. The stall is discarded because the consumer is being squashed.
- `stalled` register: next value = `stall & ~flush`.
- Held register (`held`, XLEN):
  - Loads `mem_wb_result` on every cycle where `stall & ~flush`.
  - Otherwise retains its value.
  - Captures write-back data that leaves WB while the consumer is frozen in ID.
- Operand mux, identical for A and B: 00 → `rsN_data_e`, 01 → `mem_wb_result`, 10 → `ex_mem_result`, 11 → `held`. Purely combinational.
- Counters:
  - `stall_cnt` increments on a cycle with `stall & ~flush`.
  - `flush_cnt` increments on a cycle with `flush`.
  - Both saturate at all-ones and do not wrap.
  - `cnt_clear` zeroes both counters and has priority over incrementing in the same cycle.
- Back-to-back stall (`stall` while `stalled`=1) is honored as normal: the PC stays frozen, `stall_cnt` increments, and `held` reloads.

## Timing
- Reset (asynchronous on `rst_n` low): `stalled`=0, `held`=0, `stall_cnt`=0, `flush_cnt`=0.
- Output values while in reset:
  - Stage controls and `alu_a`/`alu_b` follow their combinational inputs.
  - With `stall`=`flush`=0 the controls read normal.
- Release from reset is synchronous to `clk`. The first edge after `rst_n` rises updates state normally.
- Latency:
  - Stage controls and operand muxes: 0 cycles.
  - `stalled`, `held` and the counters: visible 1 cycle after the triggering input.
- `rst_n` asserted mid-stall clears `stalled` immediately. The next cycle behaves as non-stalled.
- No handshakes. The block never originates a stall or flush.

## Test plan
- Reset behaviour: assert `rst_n`=0 with `stall`=`flush`=0 → `stalled`=0, both counters 0, `pc_write`=1, `if_id_write`=1, `if_id_flush`=0, `id_ex_flush`=0; `forward_a`=11 gives `alu_a`=0.
- Single stall: `stall`=1 for one cycle with `mem_wb_result`=0xDEADBEEF.
  - Same cycle: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1.
  - Next cycle: `stalled`=1, `stall_cnt`=1.
  - With `forward_b`=11: `alu_b`=0xDEADBEEF, even after `mem_wb_result` changes to 0x1.
- Flush with stall: `stall`=1 and `flush`=1 together.
  - Same cycle: `pc_write`=1, `if_id_flush`=1, `id_ex_flush`=1.
  - Next cycle: `stalled`=0, `flush_cnt`=1, `stall_cnt` unchanged, `held` unchanged.
- Forward mux: `rs1_data_e`=0x11, `mem_wb_result`=0x22, `ex_mem_result`=0x33, `held`=0x44; sweep `forward_a` through 00/01/10/11 → `alu_a` = 0x11/0x22/0x33/0x44 in the same cycle. Repeat the sweep for B.
- Saturation: with `CNT_W`=4, hold `flush`=1 for 20 cycles → `flush_cnt` reaches 0xF and stays at 0xF. Then `cnt_clear`=1 together with `flush`=1 → `flush_cnt`=0 the next cycle.
- Reset mid-stall: `stall`=1 at an edge, then `rst_n` low between edges → `stalled` drops to 0 immediately without a clock edge, and `held` becomes 0.
